// File: rtl/switch_select_debounce.sv
// Synchronises and debounces two push-buttons, then commits the pair to the demux select lines
// only once it has held steady for a settle window, so no intermediate select code is ever shown.
module switch_select_debounce #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned SETTLE_LIMIT   = 25000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  output logic o_Sel0,
  output logic o_Sel1,
  output logic o_Sel_Changed
);

  localparam int unsigned DbW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int unsigned StW = (SETTLE_LIMIT > 2) ? $clog2(SETTLE_LIMIT) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_LIMIT - 1);
  localparam logic [StW-1:0] StLast = StW'(SETTLE_LIMIT - 1);

  typedef enum logic {StIdle, StSettle} state_e;

  logic [1:0]          sw_meta_q, sw_s_q;
  logic [1:0]          deb_q, deb_d;
  logic [1:0][DbW-1:0] deb_cnt_q, deb_cnt_d;

  state_e              state_q, state_d;
  logic [1:0]          pq_q, pq_d;
  logic [StW-1:0]      settle_cnt_q, settle_cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic                chg_q, chg_d;

  // Index 0 is switch 1 (select bit 0), index 1 is switch 2 (select bit 1).
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      deb_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      sw_meta_q <= {i_Switch_2, i_Switch_1};
      sw_s_q    <= sw_meta_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Any cycle agreeing with the debounced state restarts the count.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sw_s_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DbLast) begin
        deb_d[i]     = sw_s_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DbW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= StIdle;
      pq_q         <= '0;
      settle_cnt_q <= '0;
      sel_q        <= '0;
      chg_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pq_q         <= pq_d;
      settle_cnt_q <= settle_cnt_d;
      sel_q        <= sel_d;
      chg_q        <= chg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pq_d         = pq_q;
    settle_cnt_d = settle_cnt_q;
    sel_d        = sel_q;
    chg_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (deb_q != sel_q) begin
          state_d      = StSettle;
          pq_d         = deb_q;
          settle_cnt_d = '0;
        end
      end
      StSettle: begin
        // A moving pair restarts the window before anything else is considered.
        if (deb_q != pq_q) begin
          pq_d         = deb_q;
          settle_cnt_d = '0;
        end else if (deb_q == sel_q) begin
          state_d = StIdle;
        end else if (settle_cnt_q == StLast) begin
          sel_d   = pq_q;
          chg_d   = 1'b1;
          state_d = StIdle;
        end else begin
          settle_cnt_d = settle_cnt_q + StW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_Sel0        = sel_q[0];
  assign o_Sel1        = sel_q[1];
  assign o_Sel_Changed = chg_q;

endmodule

// File: tb/tb_switch_select_debounce.sv
// Directed bench for switch_select_debounce with DEBOUNCE_LIMIT=4, SETTLE_LIMIT=3: a per-cycle
// vector table plus hand-written reset sequences.
module tb_switch_select_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic sw1, sw2;
  logic sel0, sel1, sel_chg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_select_debounce #(
    .DEBOUNCE_LIMIT(4),
    .SETTLE_LIMIT  (3)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Switch_1   (sw1),
    .i_Switch_2   (sw2),
    .o_Sel0       (sel0),
    .o_Sel1       (sel1),
    .o_Sel_Changed(sel_chg)
  );

  // Row k: inputs driven just after edge k, outputs expected just after edge k+1.
  typedef struct {
    logic       sw1;
    logic       sw2;
    logic [1:0] sel;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic s1, logic s2, logic [1:0] sel, logic chg);
    vec_t v;
    v.sw1 = s1;
    v.sw2 = s2;
    v.sel = sel;
    v.chg = chg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(string name, int idx, logic [1:0] exp_sel, logic exp_chg);
    n_checks++;
    if ({sel1, sel0} !== exp_sel || sel_chg !== exp_chg) begin
      n_fail++;
      $display("FAIL %s[%0d]: got sel=%b chg=%b, expected sel=%b chg=%b",
               name, idx, {sel1, sel0}, sel_chg, exp_sel, exp_chg);
    end
  endtask

  // Called just after an edge that releases reset or changes inputs; commit lands on edge 10.
  task automatic expect_commit(string name, logic [1:0] old_sel, logic [1:0] new_sel);
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      #1;
      if (e < 10)       check(name, e, old_sel, 1'b0);
      else if (e == 10) check(name, e, new_sel, 1'b1);
      else              check(name, e, new_sel, 1'b0);
    end
  endtask

  initial begin
    // Clean transition back to 00 from 11
    add(9, 0, 0, 2'b11, 0); add(1, 0, 0, 2'b00, 1); add(4, 0, 0, 2'b00, 0);
    // Clean single edge on switch 1
    add(9, 1, 0, 2'b00, 0); add(1, 1, 0, 2'b01, 1); add(4, 1, 0, 2'b01, 0);
    add(9, 0, 0, 2'b01, 0); add(1, 0, 0, 2'b00, 1); add(4, 0, 0, 2'b00, 0);
    // Bounce 1,0,1,0 then rest low: nothing moves; then a held press commits
    add(1, 1, 0, 2'b00, 0); add(1, 0, 0, 2'b00, 0); add(1, 1, 0, 2'b00, 0);
    add(13, 0, 0, 2'b00, 0);
    add(9, 1, 0, 2'b00, 0); add(1, 1, 0, 2'b01, 1); add(4, 1, 0, 2'b01, 0);
    add(9, 0, 0, 2'b01, 0); add(1, 0, 0, 2'b00, 1); add(4, 0, 0, 2'b00, 0);
    // Skewed pair: switch 2 two cycles late, single jump 00->11 on edge 12
    add(2, 1, 0, 2'b00, 0); add(9, 1, 1, 2'b00, 0); add(1, 1, 1, 2'b11, 1);
    add(4, 1, 1, 2'b11, 0);
    add(9, 0, 0, 2'b11, 0); add(1, 0, 0, 2'b00, 1); add(4, 0, 0, 2'b00, 0);
    // Pair keeps moving inside the window and returns to 00: no commit at all
    add(2, 1, 0, 2'b00, 0); add(2, 1, 1, 2'b00, 0); add(2, 0, 1, 2'b00, 0);
    add(14, 0, 0, 2'b00, 0);
    // Leave 01 committed for the mid-settle reset sequence
    add(9, 1, 0, 2'b00, 0); add(1, 1, 0, 2'b01, 1); add(2, 1, 0, 2'b01, 0);

    rst_n = 1'b0;
    sw1   = 1'b1;
    sw2   = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      check("in_reset", e, 2'b00, 1'b0);
    end
    rst_n = 1'b1;
    expect_commit("reset_release", 2'b00, 2'b11);

    for (int k = 0; k < vecs.size(); k++) begin
      sw1 = vecs[k].sw1;
      sw2 = vecs[k].sw2;
      @(posedge clk);
      #1;
      check("vec", k, vecs[k].sel, vecs[k].chg);
    end

    // Switch 2 rises; reset lands between edge 9 and the commit edge
    sw2 = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      check("pre_reset", e, 2'b01, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 0, 2'b00, 1'b0);
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk);
      #1;
      check("held_reset", e, 2'b00, 1'b0);
    end
    rst_n = 1'b1;
    expect_commit("mid_settle_release", 2'b00, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
